// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// The trial subtraction is a ripple chain of full-adder cells; latency is WIDTH+1 edges from accept.

module seq_restoring_divider_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] r_q, q_q, d_q, quot_q, rem_q;
    logic             busy_q, done_q, dbz_q, zero_q;
    logic [WIDTH:0]   r_sh, c;
    logic [WIDTH-1:0] t, r_d, q_d;
    logic             no_borrow;

    // R never exceeds D after a restore, so only WIDTH bits of it are stored.
    assign r_sh = {r_q, q_q[WIDTH-1]};
    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        seq_restoring_divider_fa u_fa (
            .a_i(r_sh[i]),
            .b_i(~d_q[i]),
            .c_i(c[i]),
            .s_o(t[i]),
            .c_o(c[i+1])
        );
    end

    // Top position adds R'[WIDTH] to the inverted zero pad (a constant 1); only its carry matters.
    assign no_borrow = r_sh[WIDTH] | c[WIDTH];
    assign r_d = no_borrow ? t : r_sh[WIDTH-1:0];
    assign q_d = {q_q[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    q_q     <= dividend;
                    d_q     <= divisor;
                    r_q     <= '0;
                    count_q <= '0;
                    busy_q  <= 1'b1;
                    zero_q  <= (divisor == '0);
                    state_q <= RUN;
                end
            end else begin
                r_q     <= r_d;
                q_q     <= q_d;
                count_q <= count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    quot_q  <= q_d;
                    rem_q   <= r_d;
                    dbz_q   <= zero_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for the restoring divider, arithmetic reference model.
module tb_seq_restoring_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0, divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    seq_restoring_divider #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] q, r; logic z; int acc; } exp_t;
    exp_t sb[$];
    exp_t last;
    int   cyc = 0, errors = 0, checks = 0;
    bit   started = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic [7:0] a, input logic [7:0] b, input int acc);
        exp_t e;
        e.q = (b == 0) ? 8'hFF : 8'(a / b);
        e.r = (b == 0) ? a : 8'(a % b);
        e.z = (b == 0);
        e.acc = acc;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n && started) begin
            chk("busy", busy, (sb.size() > 0 && cyc >= sb[0].acc && cyc <= sb[0].acc + 7) ? 1 : 0);
            if (sb.size() > 0 && cyc >= sb[0].acc + 8) begin
                last = sb.pop_front();
                chk("done", done, 1);
                chk("quotient", quotient, last.q);
                chk("remainder", remainder, last.r);
                chk("div_by_zero", div_by_zero, last.z);
            end else begin
                chk("done_idle", done, 0);
                chk("quotient_hold", quotient, last.q);
                chk("remainder_hold", remainder, last.r);
                chk("dbz_hold", div_by_zero, last.z);
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_div(input logic [7:0] a, input logic [7:0] b, output int acc);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1 acc = cyc;
        push(a, b, acc);
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
    endtask

    task automatic div(input logic [7:0] a, input logic [7:0] b, input int gap);
        int acc;
        repeat (gap) @(negedge clk);
        start_div(a, b, acc);
        wait_until(acc + 8);
    endtask

    task automatic clear_model();
        sb.delete();
        last.q = '0;
        last.r = '0;
        last.z = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic [7:0] x, y;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        started = 1;

        div(100, 7, 1);
        div(5, 9, 2);
        div(255, 1, 0);
        div(37, 0, 1);

        repeat (2) @(negedge clk);
        start_div(200, 10, a);
        wait_until(a + 3);
        start = 1'b1;
        dividend = 50;
        divisor = 5;
        @(negedge clk);
        start = 1'b0;
        wait_until(a + 8);

        repeat (2) @(negedge clk);
        start = 1'b1;
        dividend = 200;
        divisor = 10;
        @(posedge clk);
        #1 a = cyc;
        push(200, 10, a);
        wait_until(a + 8);
        dividend = 81;
        divisor = 9;
        @(posedge clk);
        #1 push(81, 9, a + 9);
        wait_until(a + 17);
        start = 1'b0;

        repeat (2) @(negedge clk);
        start_div(100, 7, a);
        wait_until(a + 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        div(100, 7, 1);

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom_range(1, 255));
            if (i % 7 == 0) y = 8'($urandom_range(1, 15));
            div(x, y, $urandom_range(0, 2));
        end

        repeat (12) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
